fmv_rr_scheduler: RTL and testbench



---
 rtl/fmv_rr_scheduler_if.sv | 26 ++
 rtl/fmv_rr_scheduler.sv | 103 ++++++++++
 tb/tb_fmv_rr_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fmv_rr_scheduler_if.sv
// Request/response bundle between issue-side requesters and the FMV scheduler.
// The slave modport is the scheduler side; the master modport is the requester and consumer side.
interface fmv_rr_scheduler_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int XLEN = 64
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [2*NREQ-1:0]    req_op;
   logic [XLEN*NREQ-1:0] req_src;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [IDW-1:0]       resp_id;
   logic [XLEN-1:0]      resp_data;

   modport slave (
      input  req_valid, req_op, req_src, resp_ready,
      output req_ready, resp_valid, resp_id, resp_data
   );

   modport master (
      output req_valid, req_op, req_src, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_data
   );
endinterface

// File: rtl/fmv_rr_scheduler.sv
// Round-robin arbiter in front of a shared FMV datapath with a one-entry registered result buffer.
//  state | meaning
//  EMPTY | no result held, resp_valid low
//  FULL  | result held stable until resp_ready
module fmv_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int XLEN = 64
) (
   input  logic                CLK,
   input  logic                RST,
   fmv_rr_scheduler_if.slave   bus,
   output logic                busy,
   output logic [15:0]         op_count
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     grant_idx;
   logic               grant_found;
   logic               can_accept;
   logic               xfer;
   logic [1:0]         sel_op;
   logic [XLEN-1:0]    sel_src;
   logic [XLEN-1:0]    move_res;
   logic [IDW-1:0]     resp_id_q;
   logic [XLEN-1:0]    resp_data_q;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input logic [IDW:0] k);
      logic [IDW:0] s;
      s = {1'b0, base} + k;
      if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
      return s[IDW-1:0];
   endfunction

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_found && bus.req_valid[wrap_add(rr_ptr, (IDW+1)'(k))]) begin
            grant_found = 1'b1;
            grant_idx   = wrap_add(rr_ptr, (IDW+1)'(k));
         end
      end
   end

   always_comb begin
      sel_op  = 2'b00;
      sel_src = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            sel_op  = bus.req_op[2*i +: 2];
            sel_src = bus.req_src[XLEN*i +: XLEN];
         end
      end
   end

   always_comb begin
      case (sel_op)
         2'b00:   move_res = {32'hFFFF_FFFF, sel_src[31:0]};
         2'b01:   move_res = {{32{sel_src[31]}}, sel_src[31:0]};
         default: move_res = sel_src;
      endcase
   end

   // Reset also blocks acceptance so no request is consumed while RST is high.
   assign can_accept    = !RST && ((state == EMPTY) || bus.resp_ready);
   assign xfer          = can_accept && grant_found;
   assign bus.req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

   always_comb begin
      state_nxt = state;
      if (xfer)
         state_nxt = FULL;
      else if ((state == FULL) && bus.resp_ready)
         state_nxt = EMPTY;
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr      <= '0;
         resp_id_q   <= '0;
         resp_data_q <= '0;
         op_count    <= '0;
      end else if (xfer) begin
         rr_ptr      <= wrap_add(grant_idx, (IDW+1)'(1));
         resp_id_q   <= grant_idx;
         resp_data_q <= move_res;
         if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      end
   end

   assign bus.resp_valid = (state == FULL);
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_data  = resp_data_q;
   assign busy           = (state == FULL);
endmodule

// File: tb/tb_fmv_rr_scheduler.sv
// Directed bench for fmv_rr_scheduler: reset, op functions, round-robin order, backpressure, saturation.
module tb_fmv_rr_scheduler;
   logic        CLK = 1'b0;
   logic        RST;
   logic        busy;
   logic [15:0] op_count;
   int          total = 0;
   int          bad   = 0;

   fmv_rr_scheduler_if #(.NREQ(4), .IDW(2), .XLEN(64)) bus ();

   fmv_rr_scheduler #(.NREQ(4), .IDW(2), .XLEN(64)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.resp_ready = 1'b1;
      bus.req_valid  = 4'hF;
      bus.req_op     = '0;
      for (int i = 0; i < 4; i++) bus.req_src[64*i +: 64] = 64'h1000 + 64'(i);
      tick();
      tick();
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready act=%b exp=0000", bus.req_ready); end
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid act=%b exp=0", bus.resp_valid); end
      total++; if (bus.resp_data !== 64'h0) begin bad++; $display("FAIL rst_resp_data act=%h exp=0", bus.resp_data); end
      total++; if (op_count !== 16'h0) begin bad++; $display("FAIL rst_op_count act=%h exp=0", op_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy act=%b exp=0", busy); end
      RST = 1'b0;
      #1;
      total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rel_grant act=%b exp=0001", bus.req_ready); end
      tick();
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0) begin bad++; $display("FAIL rel_resp act=%b/%0d exp=1/0", bus.resp_valid, bus.resp_id); end
      total++; if (bus.resp_data !== 64'hFFFFFFFF_00001000) begin bad++; $display("FAIL rel_data act=%h exp=ffffffff00001000", bus.resp_data); end
      total++; if (op_count !== 16'd1) begin bad++; $display("FAIL rel_count act=%0d exp=1", op_count); end
      bus.req_valid = 4'h0;
      tick();
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL drain_empty act=%b exp=0", bus.resp_valid); end
   endtask

   // rr_ptr is 1 on entry.
   task automatic test_op_functions();
      bus.req_valid = 4'b0010;
      bus.req_op[3:2] = 2'b00;
      bus.req_src[64 +: 64] = 64'hC0CCCCCC_C1696042;
      #1;
      total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL nb_grant act=%b exp=0010", bus.req_ready); end
      tick();
      total++; if (bus.resp_data !== 64'hFFFFFFFF_C1696042 || bus.resp_id !== 2'd1) begin bad++; $display("FAIL nanbox act=%h/%0d exp=ffffffffc1696042/1", bus.resp_data, bus.resp_id); end
      bus.req_op[3:2] = 2'b01;
      tick();
      total++; if (bus.resp_data !== 64'hFFFFFFFF_C1696042 || bus.resp_id !== 2'd1) begin bad++; $display("FAIL sext_neg act=%h/%0d exp=ffffffffc1696042/1", bus.resp_data, bus.resp_id); end
      bus.req_src[64 +: 64] = 64'h3F28F5C2_40CCCCCC;
      tick();
      total++; if (bus.resp_data !== 64'h00000000_40CCCCCC) begin bad++; $display("FAIL sext_pos act=%h exp=0000000040cccccc", bus.resp_data); end
      total++; if (op_count !== 16'd4) begin bad++; $display("FAIL op_count4 act=%0d exp=4", op_count); end
      bus.req_valid = 4'h0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [63:0] src [4];
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bus.req_op = 8'b10_10_10_10;
      for (int i = 0; i < 4; i++) begin
         src[i] = 64'hA5A5_0000_0000_0000 | 64'(i + 16);
         bus.req_src[64*i +: 64] = src[i];
      end
      bus.req_valid = 4'hF;
      for (int n = 0; n < 6; n++) begin
         tick();
         total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(n % 4)) begin bad++; $display("FAIL rr_id[%0d] act=%b/%0d exp=1/%0d", n, bus.resp_valid, bus.resp_id, n % 4); end
         total++; if (bus.resp_data !== src[n % 4]) begin bad++; $display("FAIL rr_data[%0d] act=%h exp=%h", n, bus.resp_data, src[n % 4]); end
      end
      total++; if (op_count !== 16'd6) begin bad++; $display("FAIL rr_count act=%0d exp=6", op_count); end
      bus.req_valid = 4'h0;
      tick();
   endtask

   // rr_ptr is 2 on entry.
   task automatic test_backpressure();
      bus.req_valid = 4'b0001;
      bus.req_op[1:0] = 2'b00;
      bus.req_src[0 +: 64] = 64'h12345678_87654321;
      tick();
      bus.resp_ready = 1'b0;
      bus.req_valid  = 4'b0100;
      bus.req_op[5:4] = 2'b10;
      bus.req_src[128 +: 64] = 64'h3F28F5C2_40CCCCCC;
      for (int n = 0; n < 3; n++) begin
         #1;
         total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] act=%b exp=0000", n, bus.req_ready); end
         tick();
         total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_data !== 64'hFFFFFFFF_87654321) begin
            bad++; $display("FAIL bp_hold[%0d] act=%b/%0d/%h exp=1/0/ffffffff87654321", n, bus.resp_valid, bus.resp_id, bus.resp_data);
         end
      end
      bus.resp_ready = 1'b1;
      #1;
      total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release act=%b exp=0100", bus.req_ready); end
      tick();
      total++; if (bus.resp_id !== 2'd2 || bus.resp_data !== 64'h3F28F5C2_40CCCCCC) begin bad++; $display("FAIL bp_result act=%0d/%h exp=2/3f28f5c240cccccc", bus.resp_id, bus.resp_data); end
      bus.req_valid = 4'h0;
      tick();
   endtask

   // rr_ptr is 3 on entry; requester 0 still wins since it is the only one valid.
   task automatic test_reset_mid();
      bus.req_valid = 4'b0001;
      tick();
      total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL mid_full act=%b exp=1", bus.resp_valid); end
      RST = 1'b1;
      bus.resp_ready = 1'b1;
      bus.req_valid = 4'hF;
      #1;
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready act=%b exp=0000", bus.req_ready); end
      tick();
      total++; if (bus.resp_valid !== 1'b0 || op_count !== 16'd0 || bus.resp_data !== 64'h0) begin
         bad++; $display("FAIL mid_reset act=%b/%0d/%h exp=0/0/0", bus.resp_valid, op_count, bus.resp_data);
      end
      RST = 1'b0;
      #1;
      total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr act=%b exp=0001", bus.req_ready); end
      bus.req_valid = 4'h0;
      tick();
   endtask

   task automatic test_saturation();
      logic [63:0] s;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bus.resp_ready = 1'b1;
      bus.req_op[7:6] = 2'b11;
      bus.req_valid = 4'b1000;
      for (int n = 0; n < 65537; n++) begin
         s = {32'(n) * 32'h9E37_79B9, 32'(n) ^ 32'h8000_0000};
         bus.req_src[192 +: 64] = s;
         tick();
         total++; if (bus.resp_data !== s || bus.resp_id !== 2'd3) begin bad++; $display("FAIL sat_data[%0d] act=%h/%0d exp=%h/3", n, bus.resp_data, bus.resp_id, s); end
         if (n == 65533) begin
            total++; if (op_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre act=%h exp=fffe", op_count); end
         end
      end
      total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold act=%h exp=ffff", op_count); end
      bus.req_valid = 4'h0;
      tick();
   endtask

   initial begin
      RST = 1'b1;
      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_src    = '0;
      bus.resp_ready = 1'b0;
      #2;
      test_reset();
      test_op_functions();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
